// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate stage: state encoding,
// default widths and writeback saturation limits.
package fir_pkg;

  localparam int FIR_DATA_W  = 8;
  localparam int FIR_ADDR_W  = 3;
  localparam int FIR_GUARD_W = 4;
  localparam int FIR_ACC_W   = 2 * FIR_DATA_W + FIR_GUARD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2,
    WB   = 2'd3
  } macStateT;

  // Signed writeback range limits used when saturation is enabled
  localparam logic [FIR_DATA_W-1:0] SAT_MAX = 8'h7F;
  localparam logic [FIR_DATA_W-1:0] SAT_MIN = 8'h80;

endpackage

// File: rtl/fir_mac_unit_multiplier.sv
// Unsigned shift-add multiplier for operand magnitudes. The top module
// drives one step per cycle and supplies its down-counter; ready marks the
// step taken while the counter is at zero, i.e. the last one.
// The magnitude of the most negative operand needs DATA_W+1 bits, so the
// inputs are one bit wider than the data path. Bit DATA_W of the multiplier
// is folded in at load time (preloading mcand << DATA_W), leaving DATA_W
// steps for the remaining bits.
module shift_add_multiplier
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int CNT_W  = $clog2(FIR_DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [CNT_W-1:0]      count,
  input  logic [DATA_W:0]       mcandIn,
  input  logic [DATA_W:0]       mplierIn,
  output logic [2*DATA_W+1:0]   product,
  output logic                  ready
);

  localparam int MAG_W  = DATA_W + 1;
  localparam int PROD_W = 2 * MAG_W;

  logic [PROD_W-1:0] mcandR;
  logic [PROD_W-1:0] productR;
  logic [DATA_W-1:0] mplierR;

  // Load operands, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcandR   <= '0;
      mplierR  <= '0;
      productR <= '0;
    end else if (load) begin
      mcandR   <= {{MAG_W{1'b0}}, mcandIn};
      mplierR  <= mplierIn[DATA_W-1:0];
      productR <= mplierIn[DATA_W] ? ({{MAG_W{1'b0}}, mcandIn} << DATA_W) : '0;
    end else if (step) begin
      if (mplierR[0]) begin
        productR <= productR + mcandR;
      end
      mcandR  <= mcandR << 1;
      mplierR <= mplierR >> 1;
    end
  end

  assign ready   = step && (count == {CNT_W{1'b0}});
  assign product = productR;

endmodule

// File: rtl/fir_mac_unit.sv
// Multi-cycle signed multiply-accumulate stage for the FIR datapath.
// Operands come from the register-file read ports; the accumulated result
// is written back through registered regWrite/writeRegister/writeData,
// held stable for the whole WB cycle because the register file writes on
// the falling edge.
// Optional build macro: FIR_MAC_SATURATE_EN -- when defined, writeData is
// clamped to the signed DATA_W range instead of wrapping.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W    = FIR_DATA_W,
  parameter int ADDR_W    = FIR_ADDR_W,
  parameter int GUARD_W   = FIR_GUARD_W,
  parameter int FRAC_BITS = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clearAcc,
  input  logic [DATA_W-1:0]             operandA,
  input  logic [DATA_W-1:0]             operandB,
  input  logic [ADDR_W-1:0]             destRegister,
  output logic                          busy,
  output logic                          done,
  output logic                          regWrite,
  output logic [ADDR_W-1:0]             writeRegister,
  output logic [DATA_W-1:0]             writeData,
  output logic [2*DATA_W+GUARD_W-1:0]   accOut
);

  localparam int ACC_W  = 2 * DATA_W + GUARD_W;
  localparam int MAG_W  = DATA_W + 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int CNT_W  = $clog2(DATA_W);

  macStateT state, nextState;

  logic               accept, mulStep, doAcc, idleClear, mulReady;
  logic [CNT_W-1:0]   countR;
  logic               signR, clearR;
  logic [ADDR_W-1:0]  destR;
  logic [MAG_W-1:0]   magA, magB;
  logic [PROD_W-1:0]  mulProduct;
  logic [ACC_W-1:0]   accR, accNext, prodExt, prodSigned;
  logic [DATA_W-1:0]  wbData;
  logic               busyR, doneR, regWriteR;
  logic [ADDR_W-1:0]  writeRegR;
  logic [DATA_W-1:0]  writeDataR;

  // Two's-complement magnitude, one bit wider so -2^(DATA_W-1) is representable
  function automatic logic [MAG_W-1:0] magOf(input logic [DATA_W-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[DATA_W-1], v};
    if (ext[MAG_W-1]) begin
      return (~ext) + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      return ext;
    end
  endfunction

  assign magA = magOf(operandA);
  assign magB = magOf(operandB);

  shift_add_multiplier #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) uMult (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (mulStep),
    .count    (countR),
    .mcandIn  (magA),
    .mplierIn (magB),
    .product  (mulProduct),
    .ready    (mulReady)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    mulStep   = 1'b0;
    doAcc     = 1'b0;
    idleClear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = MULT;
        end else if (clearAcc) begin
          idleClear = 1'b1;
          nextState = IDLE;
        end else begin
          nextState = IDLE;
        end
      end
      MULT: begin
        mulStep = 1'b1;
        if (mulReady) begin
          nextState = ACC;
        end else begin
          nextState = MULT;
        end
      end
      ACC: begin
        doAcc     = 1'b1;
        nextState = WB;
      end
      WB: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Multiply step counter: DATA_W-1 down to 0 while in MULT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countR <= '0;
    end else if (accept) begin
      countR <= CNT_W'(DATA_W - 1);
    end else if (mulStep && (countR != {CNT_W{1'b0}})) begin
      countR <= countR - CNT_W'(1);
    end
  end

  // Capture sign, destination and clear mode when an operation is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signR  <= 1'b0;
      clearR <= 1'b0;
      destR  <= '0;
    end else if (accept) begin
      signR  <= operandA[DATA_W-1] ^ operandB[DATA_W-1];
      clearR <= clearAcc;
      destR  <= destRegister;
    end
  end

  // Apply the sign to the magnitude product and form the new accumulator
  always_comb begin
    prodExt = {{(ACC_W-PROD_W){1'b0}}, mulProduct};
    if (signR) begin
      prodSigned = (~prodExt) + {{(ACC_W-1){1'b0}}, 1'b1};
    end else begin
      prodSigned = prodExt;
    end
    if (clearR) begin
      accNext = prodSigned;
    end else begin
      accNext = accR + prodSigned;
    end
  end

`ifdef FIR_MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'($signed(SAT_MAX));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'($signed(SAT_MIN));
  logic signed [ACC_W-1:0] accShift;

  // Writeback slice clamped to the signed DATA_W range
  always_comb begin
    accShift = $signed(accNext) >>> FRAC_BITS;
    if (accShift > SAT_HI) begin
      wbData = SAT_MAX;
    end else if (accShift < SAT_LO) begin
      wbData = SAT_MIN;
    end else begin
      wbData = accShift[DATA_W-1:0];
    end
  end
`else
  // Writeback slice taken straight from the accumulator (wraps)
  always_comb begin
    wbData = accNext[FRAC_BITS+DATA_W-1:FRAC_BITS];
  end
`endif

  // Accumulator and registered status/writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accR       <= '0;
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      regWriteR  <= 1'b0;
      writeRegR  <= '0;
      writeDataR <= '0;
    end else begin
      if (accept) begin
        busyR <= 1'b1;
      end else if (state == WB) begin
        busyR <= 1'b0;
      end
      if (doAcc) begin
        accR       <= accNext;
        doneR      <= 1'b1;
        regWriteR  <= (destR != {ADDR_W{1'b0}});
        writeRegR  <= destR;
        writeDataR <= wbData;
      end else if (state == WB) begin
        doneR      <= 1'b0;
        regWriteR  <= 1'b0;
        writeRegR  <= '0;
        writeDataR <= '0;
      end else if (idleClear) begin
        accR <= '0;
      end
    end
  end

  assign busy          = busyR;
  assign done          = doneR;
  assign regWrite      = regWriteR;
  assign writeRegister = writeRegR;
  assign writeData     = writeDataR;
  assign accOut        = accR;

endmodule

// File: tb/tb_fir_mac_unit.sv
// Self-checking bench for fir_mac_unit: directed vector table, randomized
// operations against a plain-arithmetic accumulator model, and reset corner
// cases. Honors FIR_MAC_SATURATE_EN for the expected writeback data.
module tb_fir_mac_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clearAcc;
  logic [7:0]  operandA;
  logic [7:0]  operandB;
  logic [2:0]  destRegister;
  logic        busy;
  logic        done;
  logic        regWrite;
  logic [2:0]  writeRegister;
  logic [7:0]  writeData;
  logic [19:0] accOut;

  int nChecks = 0;
  int nFail   = 0;
  logic [19:0] refAcc;

  fir_mac_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .clearAcc      (clearAcc),
    .operandA      (operandA),
    .operandB      (operandB),
    .destRegister  (destRegister),
    .busy          (busy),
    .done          (done),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .accOut        (accOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        clr;
    logic [2:0]  dest;
    bit          poke;
    logic [19:0] eAcc;
    logic [7:0]  eWrap;
    logic [7:0]  eSat;
  } vecT;

  vecT tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected writeback byte from the full accumulator value
  function automatic logic [7:0] expWd(input logic [19:0] acc);
`ifdef FIR_MAC_SATURATE_EN
    int v;
    v = int'($signed(acc));
    if (v > 127) return 8'h7F;
    else if (v < -128) return 8'h80;
    else return acc[7:0];
`else
    return acc[7:0];
`endif
  endfunction

  // One MAC operation: issue, time it, check the WB cycle and the return to idle.
  // poke re-pulses start/clearAcc during MULT; both must be ignored.
  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic clr,
                       input logic [2:0] dest, input bit poke,
                       input logic [19:0] eAcc, input logic [7:0] eWd);
    int cyc;
    bit seen;
    bit busyBad;
    int extra;
    @(posedge clk); #1;
    operandA = a; operandB = b; clearAcc = clr; destRegister = dest; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clearAcc = ~clr;
    operandA = 8'($urandom);
    operandB = 8'($urandom);
    destRegister = 3'($urandom);
    cyc = 0; seen = 1'b0; busyBad = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busyBad = 1'b1;
        start = (poke && cyc == 3);
        if (poke && cyc == 3) clearAcc = 1'b1;
      end
    end
    clearAcc = 1'b0;
    start = 1'b0;
    check("latency", 32'(cyc), 32'd10);
    check("busyRun", 32'(busyBad), 32'd0);
    check("busyWb", 32'(busy), 32'd1);
    check("regWrite", 32'(regWrite), 32'(dest != 3'd0));
    check("writeRegister", 32'(writeRegister), 32'(dest));
    check("writeData", 32'(writeData), 32'(eWd));
    check("accOut", 32'(accOut), 32'(eAcc));
    @(negedge clk);
    check("doneDrop", 32'(done), 32'd0);
    check("busyDrop", 32'(busy), 32'd0);
    check("wbIdle", 32'({regWrite, writeRegister, writeData}), 32'd0);
    if (poke) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("extraDone", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic rc;
    logic [2:0] rd;
    logic [7:0] eWd;
    int prod;
    int waitCyc;

    tbl[0] = '{8'd3,   8'd5,   1'b1, 3'd1, 1'b0, 20'd15,    8'h0F, 8'h0F};
    tbl[1] = '{8'hFE,  8'd4,   1'b0, 3'd2, 1'b0, 20'd7,     8'h07, 8'h07};
    tbl[2] = '{8'd100, 8'd100, 1'b1, 3'd3, 1'b1, 20'd10000, 8'h10, 8'h7F};
    tbl[3] = '{8'h80,  8'd127, 1'b1, 3'd4, 1'b0, 20'hFC080, 8'h80, 8'h80};
    tbl[4] = '{8'h80,  8'h80,  1'b1, 3'd5, 1'b0, 20'h04000, 8'h00, 8'h7F};
    tbl[5] = '{8'h81,  8'h7F,  1'b0, 3'd0, 1'b0, 20'h000FF, 8'hFF, 8'h7F};
    tbl[6] = '{8'h00,  8'h55,  1'b0, 3'd7, 1'b1, 20'h000FF, 8'hFF, 8'h7F};
    tbl[7] = '{8'hFF,  8'hFF,  1'b1, 3'd6, 1'b0, 20'd1,     8'h01, 8'h01};

    rst = 1'b1; start = 1'b0; clearAcc = 1'b0;
    operandA = 8'd0; operandB = 8'd0; destRegister = 3'd0;
    repeat (2) @(negedge clk);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstDone", 32'(done), 32'd0);
    check("rstAcc", 32'(accOut), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("postRstBusy", 32'(busy), 32'd0);
    check("postRstAcc", 32'(accOut), 32'd0);
    refAcc = 20'd0;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
`ifdef FIR_MAC_SATURATE_EN
      eWd = tbl[i].eSat;
`else
      eWd = tbl[i].eWrap;
`endif
      runOp(tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].dest, tbl[i].poke, tbl[i].eAcc, eWd);
      refAcc = tbl[i].eAcc;
    end

    // clearAcc alone in IDLE zeroes the accumulator
    @(posedge clk); #1;
    clearAcc = 1'b1;
    @(posedge clk); #1;
    clearAcc = 1'b0;
    @(negedge clk);
    check("idleClear", 32'(accOut), 32'd0);
    check("idleClearBusy", 32'(busy), 32'd0);
    refAcc = 20'd0;

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = ($urandom_range(0, 3) == 0);
      rd = 3'($urandom_range(0, 7));
      prod = int'($signed(ra)) * int'($signed(rb));
      if (rc) refAcc = 20'(prod);
      else refAcc = 20'(int'(refAcc) + prod);
      runOp(ra, rb, rc, rd, 1'b0, refAcc, expWd(refAcc));
    end

    // Reset asserted mid-cycle during MULT
    @(posedge clk); #1;
    operandA = 8'd9; operandB = 8'd9; clearAcc = 1'b0; destRegister = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mulRstBusy", 32'(busy), 32'd0);
    check("mulRstAcc", 32'(accOut), 32'd0);
    check("mulRstWb", 32'({done, regWrite, writeRegister, writeData}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitCyc = 0;
    repeat (14) begin
      @(negedge clk);
      if (done || regWrite) waitCyc++;
    end
    check("mulRstNoDone", 32'(waitCyc), 32'd0);
    refAcc = 20'd0;
    runOp(8'd2, 8'd2, 1'b0, 3'd3, 1'b0, 20'd4, expWd(20'd4));

    // Reset asserted mid-cycle while the WB outputs are up
    @(posedge clk); #1;
    operandA = 8'd100; operandB = 8'd100; clearAcc = 1'b1; destRegister = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clearAcc = 1'b0;
    waitCyc = 0;
    while (!done && waitCyc < 30) begin
      @(negedge clk);
      waitCyc++;
    end
    check("wbSeen", 32'(done), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("wbRstBusy", 32'(busy), 32'd0);
    check("wbRstCtl", 32'({done, regWrite, writeRegister}), 32'd0);
    check("wbRstData", 32'(writeData), 32'd0);
    check("wbRstAcc", 32'(accOut), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fir_mac_unit.md
Name: fir_mac_unit

Overview:
- Multi-cycle signed multiply-accumulate stage for the FIR datapath.
- Consumes the two register-file read ports as operands and accumulates the product.
- Feeds the result back to the register-file write port.
- The register file writes on negedge clk, so every writeback output here is registered on posedge and held for one full cycle.

Parameters:
- DATA_W, 8, operand and writeback width; matches register-file data width.
- ADDR_W, 3, register address width; matches 8-entry register file.
- GUARD_W, 4, extra accumulator MSBs; accumulator width ACC_W = 2*DATA_W + GUARD_W = 20.
- FRAC_BITS, 0, LSB index of the writeback slice taken from the accumulator.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one MAC operation; sampled only in IDLE.
- clearAcc  input  1  with start: product replaces accumulator; without start in IDLE: accumulator cleared.
- operandA  input  DATA_W  signed operand, driven from readData1.
- operandB  input  DATA_W  signed operand, driven from readData2.
- destRegister  input  ADDR_W  writeback target, captured with start.
- busy  output  1  high from the cycle after start acceptance through the WB cycle.
- done  output  1  one-cycle pulse in WB.
- regWrite  output  1  write strobe to the register file.
- writeRegister  output  ADDR_W  write address to the register file.
- writeData  output  DATA_W  write data to the register file.
- accOut  output  ACC_W  full accumulator value, two's complement.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; accumulator, product, counter, busy, done, regWrite, writeRegister and writeData all 0.
- States:
  - IDLE. On start=1: latch |operandA|, |operandB|, sign = signA XOR signB, destRegister and clearAcc; go to MULT.
  - IDLE, start=0, clearAcc=1: accumulator becomes 0; stay in IDLE.
  - MULT: one shift-add step per cycle for DATA_W cycles (counter DATA_W-1 down to 0); then go to ACC.
  - ACC: signed product = negated magnitude product if sign=1, otherwise the magnitude product, sign-extended to ACC_W. Accumulator becomes the product (latched clearAcc=1) or accumulator + product (clearAcc=0). Wraps modulo 2^ACC_W. Go to WB.
  - WB: done=1; writeRegister = latched destination; writeData = accumulator[FRAC_BITS+DATA_W-1 : FRAC_BITS]. regWrite=1 unless the latched destination is 0 (suppressed; done still pulses). Return to IDLE.
- Latency: start accepted at posedge k; done/regWrite high in cycle k+DATA_W+2 (k+10 at default). Back-to-back throughput is one operation per DATA_W+3 cycles.
- Operand magnitude of -2^(DATA_W-1) (0x80) is DATA_W+1 bits wide; the multiplier datapath is sized for it.
- start while busy: ignored and not queued. clearAcc outside IDLE: ignored.
- Operands are sampled only at acceptance; changes afterwards have no effect.
- regWrite, writeRegister and writeData are 0 outside WB.

Optional Feature:
- Macro: FIR_MAC_SATURATE_EN.
- Defined: writeData saturates to signed DATA_W range. Accumulator value >> FRAC_BITS above 0x7F gives 0x7F; below -128 gives 0x80. Accumulator itself is unchanged.
- Undefined: writeData is the plain slice (wrap).

Decomposition:
- Shared package fir_pkg:
  - state encoding (IDLE=2'd0, MULT=2'd1, ACC=2'd2, WB=2'd3);
  - DATA_W, ADDR_W and ACC_W defaults;
  - the saturation limit constants.
- One natural sub-module, shift_add_multiplier:
  - unsigned DATA_W+1-bit magnitudes in, product and ready out;
  - controlled by the MULT counter.
- Sign handling, accumulation and writeback stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; after release, busy=0 and accOut=0.
- A=3, B=5, clearAcc=1, dest=1 -> busy for cycles 1..10; cycle 10: done=1, regWrite=1, writeRegister=1, writeData=0x0F, accOut=15.
- Then A=0xFE(-2), B=4, clearAcc=0, dest=2 -> accOut=7, writeData=0x07, writeRegister=2.
- A=100, B=100, clearAcc=1:
  - accOut=10000; writeData=0x10 without the macro, 0x7F with it.
  - Then A=0x80, B=127, clearAcc=1 -> accOut=-16256; writeData=0x80 with the macro.
- start pulsed during MULT -> ignored, exactly one done. dest=0 -> done=1 with regWrite=0.
- rst asserted in MULT cycle 4 -> IDLE at once, no done/regWrite, accOut=0. Next operation A=2, B=2, clearAcc=0 -> accOut=4.
